mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences a single-port, fixed-latency word memory shared between the instruction-fetch requester and the data (load/store) requester of the pipelined MIPS core. One access is in flight at a time. The data port normally has priority, and a starvation guard forces a fetch grant after repeated losses. The block sits between the IF/MEM pipeline stages and the unified memory macro (8192 x 32).

## Interface
Parameters:
- WORD_AW, 13: word-address width of the memory (8192 words).
- MEM_LAT, 1: cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..4.
- STARVE_MAX, 3: number of consecutive fetch losses after which fetch wins the next arbitration; legal range 1..7.

Ports:
- clk1  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until `if_ack`.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetched word; valid while `if_ack` is high and held until the next fetch ack.
- d_req  in  1  data request; held until `d_ack`.
- d_we  in  1  1 = store, 0 = load; qualified by `d_req`.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  32  load word; valid on a load `d_ack` and held until the next load ack.
- mem_en  out  1  memory access strobe, high exactly one cycle per access.
- mem_we  out  1  write enable; meaningful only while `mem_en` is high.
- mem_addr  out  WORD_AW  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid exactly MEM_LAT cycles after the `mem_en` cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE:** requests are sampled here.
  - If any request is present, latch the owner, the address, `we` (0 for fetch) and `wdata`, then go to ACCESS.
  - If no request is present, stay in IDLE.
- **ACCESS:** `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` are driven from the latch. Load the latency counter with MEM_LAT-1 and go to WAIT.
- **WAIT:** the counter decrements each cycle.
  - At count 0, `mem_rdata` is valid.
  - For a load or fetch, capture `mem_rdata` into the owner's rdata register and go to RESP.
- **RESP:** the owner's ack is high for this cycle only. Requests are not sampled in RESP. Next state is IDLE.
- Arbitration when both requests are high in IDLE:
  - Data wins and the starvation counter increments.
  - Exception: if the starvation counter equals STARVE_MAX, fetch wins.
- The starvation counter clears whenever fetch is granted. It holds when only data requests.
- Address mapping: `mem_addr` = addr[WORD_AW+1:2].
  - addr[1:0] is ignored (no misalign trap).
  - Bits above WORD_AW+1 are ignored, so addresses wrap modulo 32 KB.
- Stores: ack timing is identical to loads, and `d_rdata` is unchanged on a store ack.
- A requester dropping its req after latch but before ack is a protocol violation. The latched access still completes and the ack still pulses.
- Reset values:
  - state = IDLE.
  - `mem_en`, `mem_we`, `if_ack`, `d_ack`, `busy` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - Starvation counter and latency counter = 0.
- Reset mid-access aborts the transaction:
  - `mem_en` is low in the cycle after reset is sampled.
  - No ack is issued and any returning `mem_rdata` is discarded.
  - The requester must re-request.

## Timing
- All outputs are registered.
- A request sampled in IDLE in cycle k gives:
  - `mem_en` high in cycle k+1.
  - `mem_rdata` sampled at the end of cycle k+1+MEM_LAT.
  - ack high in cycle k+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles. For MEM_LAT=1 that is 3 cycles.
- Back-to-back: the next IDLE is cycle k+3+MEM_LAT, so peak throughput is one access per MEM_LAT+3 cycles.
- A requester updates req/addr on the edge that ends its ack cycle. The new request is seen in the following IDLE.
- A request arriving in ACCESS, WAIT or RESP waits for the next IDLE. It is never dropped.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum (IDLE/ACCESS/WAIT/RESP),
  - the owner encoding (OWN_IF=0, OWN_D=1),
  - the `WORD_W`=32 constant.
- One sub-module, `mem_arb_sel`:
  - combinational winner select from `if_req`, `d_req` and the starvation counter,
  - plus the registered starvation counter update.
  - The FSM, latch and latency counter stay in the top module.

## Test plan
Defaults throughout: MEM_LAT=1, STARVE_MAX=3.
- **Single fetch:** `if_req`=1, `if_addr`=0x0000_0010 at cycle 0 → `mem_en`=1, `mem_addr`=4, `mem_we`=0 in cycle 1; mem returns 0x2001_0005 → `if_ack`=1, `if_rdata`=0x2001_0005 in cycle 3; `busy`=1 in cycles 1–3.
- **Store then load:** `d_req`, `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEAD_BEEF → `mem_we`=1, `mem_addr`=0x10; `d_ack` fires with `d_rdata` unchanged. A load of 0x40 then returns 0xDEAD_BEEF.
- **Starvation:** both requests held continuously → grant order D,D,D,IF,D,D,D,IF; the counter reads 3 before each IF grant.
- **Simultaneous single request each:** both rise together → data acked first in cycle 3, fetch `mem_en` in cycle 5, fetch ack in cycle 7.
- **Wrap and misalign:** `d_addr`=0x0000_8043 → `mem_addr`=0x0010.
- **Reset mid-access:** assert rst in the WAIT cycle of a fetch → no `if_ack`; all outputs 0 the next cycle; a re-request completes normally after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memory-side blocks: arbiter FSM states,
// requester owner encoding and the datapath word width.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Winner select between fetch and data requests, with the starvation counter
// that hands fetch the grant after STARVE_MAX consecutive losses.
module mem_arb_sel
    import mips_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic   clk1,
    input  logic   rst,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   d_req,
    output logic   grant_valid,
    output owner_t grant_owner
);

    logic [2:0] starve_cnt;

    always_comb begin
        grant_valid = arb_en && (if_req || d_req);
        grant_owner = OWN_D;
        if (if_req && (!d_req || (starve_cnt == 3'(STARVE_MAX)))) begin
            grant_owner = OWN_IF;
        end
    end

    // Only a lost fetch (both requesting, data wins) counts as starvation.
    always_ff @(posedge clk1) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_valid) begin
            if (grant_owner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (if_req) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and load/store,
// one access in flight, all outputs registered.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int WORD_AW    = 13,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               if_req,
    input  logic [WORD_W-1:0]  if_addr,
    output logic               if_ack,
    output logic [WORD_W-1:0]  if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [WORD_W-1:0]  d_addr,
    input  logic [WORD_W-1:0]  d_wdata,
    output logic               d_ack,
    output logic [WORD_W-1:0]  d_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic               busy
);

    arb_state_t state;
    owner_t     owner;
    logic       lat_we;
    logic [1:0] lat_cnt;
    logic       grant_valid;
    owner_t     grant_owner;

    // Byte offset and the bits above the memory size are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[WORD_W-1:WORD_AW+2], if_addr[1:0],
                                d_addr[WORD_W-1:WORD_AW+2], d_addr[1:0]};

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk1        (clk1),
        .rst         (rst),
        .arb_en      (state == IDLE),
        .if_req      (if_req),
        .d_req       (d_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The mem_* registers double as the request latch so the macro sees
    // stable registered signals for the whole access.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_owner;
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ACCESS;
                        if (grant_owner == OWN_IF) begin
                            mem_addr <= if_addr[WORD_AW+1:2];
                            mem_we   <= 1'b0;
                            lat_we   <= 1'b0;
                        end else begin
                            mem_addr  <= d_addr[WORD_AW+1:2];
                            mem_we    <= d_we;
                            lat_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_we  <= 1'b0;
                    lat_cnt <= 2'(MEM_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        state <= RESP;
                        if (owner == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!lat_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random fetch/data traffic, all checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int WORD_AW    = 13;
    localparam int MEM_LAT    = 1;
    localparam int STARVE_MAX = 3;
    localparam int MEM_WORDS  = 8192;

    logic               clk1;
    logic               rst;
    logic               if_req;
    logic [31:0]        if_addr;
    logic               if_ack;
    logic [31:0]        if_rdata;
    logic               d_req;
    logic               d_we;
    logic [31:0]        d_addr;
    logic [31:0]        d_wdata;
    logic               d_ack;
    logic [31:0]        d_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [WORD_AW-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(
        .WORD_AW    (WORD_AW),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    function automatic logic [31:0] seed_word(input int i);
        if (i == 4) return 32'h2001_0005;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a % 32'd32768) / 32'd4);
    endfunction

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 15)) << 2) | ($urandom() & 32'hFFFF_8003);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory macro: fixed MEM_LAT read pipeline, write on the strobe cycle.
    logic [31:0] mem_arr [MEM_WORDS];
    logic [31:0] rd_pipe [MEM_LAT];
    bit          mem_init = 1'b0;
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk1) begin
        if (!mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] <= seed_word(i);
            mem_init <= 1'b1;
        end else if (mem_en) begin
            rd_pipe[0] <= mem_arr[mem_addr];
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        end
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Transaction-level reference: one grant per MEM_LAT+3 cycles at most,
    // ack MEM_LAT+2 cycles after the grant, data wins unless fetch starved.
    logic [31:0] ref_mem [MEM_WORDS];
    int          cyc = 0;
    int          next_idle = 0;
    int          rst_cycle = -10;
    int          g_cycle = -100;
    int          m_starve = 0;
    bit          g_own_if;
    bit          g_we;
    int          g_word;
    logic [31:0] g_wdata;
    logic [31:0] g_data;
    bit          take_if;

    always @(posedge clk1) begin
        if (cyc == 0) begin
            for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);
        end
        if (rst) begin
            rst_cycle = cyc;
            next_idle = cyc + 1;
            g_cycle   = -100;
            m_starve  = 0;
        end else if (cyc >= next_idle && (if_req || d_req)) begin
            take_if = if_req && (!d_req || m_starve == STARVE_MAX);
            if (take_if) m_starve = 0;
            else if (if_req) m_starve++;
            g_own_if  = take_if;
            g_cycle   = cyc;
            next_idle = cyc + MEM_LAT + 3;
            if (take_if) begin
                g_word = word_of(if_addr);
                g_we   = 1'b0;
                g_data = ref_mem[g_word];
            end else begin
                g_word  = word_of(d_addr);
                g_we    = d_we;
                g_wdata = d_wdata;
                g_data  = ref_mem[g_word];
                if (d_we) ref_mem[g_word] = d_wdata;
            end
        end
        cyc++;
    end

    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    bit          chk_on = 1'b0;
    int          ack_cyc;

    always @(negedge clk1) begin
        ack_cyc = g_cycle + MEM_LAT + 2;
        if (cyc == rst_cycle + 1) begin
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
        end
        if (cyc == ack_cyc) begin
            if (g_own_if) exp_if_rdata = g_data;
            else if (!g_we) exp_d_rdata = g_data;
        end
        if (chk_on) begin
            checkOutput("mem_en", mem_en, cyc == g_cycle + 1);
            if (cyc == g_cycle + 1) begin
                checkOutput("mem_addr", 32'(mem_addr), 32'(g_word));
                checkOutput("mem_we", mem_we, g_we);
                if (g_we) checkOutput("mem_wdata", mem_wdata, g_wdata);
            end
            checkOutput("busy", busy, cyc >= g_cycle + 1 && cyc <= ack_cyc);
            checkOutput("if_ack", if_ack, cyc == ack_cyc && g_own_if);
            checkOutput("d_ack", d_ack, cyc == ack_cyc && !g_own_if);
            checkOutput("if_rdata", if_rdata, exp_if_rdata);
            checkOutput("d_rdata", d_rdata, exp_d_rdata);
        end
    end

    task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr,
                                 input bit dw, input logic [31:0] da, input logic [31:0] dwd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    task automatic waitAck(input bit is_if, input int budget, output int took);
        took = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk1);
            if (is_if ? if_ack : d_ack) begin
                took = i;
                break;
            end
        end
    endtask

    int         took;
    int         got;
    logic [7:0] seq;

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk1);
        chk_on = 1'b1;
        checkOutput("reset_mem_en", mem_en, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 0);
        checkOutput("reset_if_rdata", if_rdata, 0);
        rst = 1'b0;

        $display("[TB] single fetch");
        @(negedge clk1);
        applyStimulus(1, 32'h0000_0010, 0, 0, 0, 0);
        @(negedge clk1);
        checkOutput("fetch_mem_en", mem_en, 1);
        checkOutput("fetch_mem_addr", 32'(mem_addr), 4);
        checkOutput("fetch_mem_we", mem_we, 0);
        @(negedge clk1);
        checkOutput("fetch_busy_c2", busy, 1);
        @(negedge clk1);
        checkOutput("fetch_if_ack", if_ack, 1);
        checkOutput("fetch_if_rdata", if_rdata, 32'h2001_0005);
        checkOutput("fetch_busy_c3", busy, 1);
        if_req = 1'b0;

        $display("[TB] store then load");
        @(negedge clk1);
        applyStimulus(0, 0, 1, 1, 32'h0000_0040, 32'hDEAD_BEEF);
        @(negedge clk1);
        checkOutput("store_mem_we", mem_we, 1);
        checkOutput("store_mem_addr", 32'(mem_addr), 32'h10);
        checkOutput("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        waitAck(0, 10, took);
        checkOutput("store_ack_lat", took, 2);
        checkOutput("store_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        @(negedge clk1);
        applyStimulus(0, 0, 1, 0, 32'h0000_0040, 0);
        waitAck(0, 10, took);
        checkOutput("load_ack_lat", took, 3);
        checkOutput("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;

        $display("[TB] wrap and misalign");
        @(negedge clk1);
        applyStimulus(0, 0, 1, 0, 32'h0000_8043, 0);
        @(negedge clk1);
        checkOutput("wrap_mem_addr", 32'(mem_addr), 32'h10);
        waitAck(0, 10, took);
        checkOutput("wrap_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;

        $display("[TB] simultaneous requests");
        @(negedge clk1);
        applyStimulus(1, 32'h0000_0008, 1, 0, 32'h0000_000C, 0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk1);
            checkOutput($sformatf("simul_d_ack_c%0d", c), d_ack, c == 3);
            checkOutput($sformatf("simul_if_ack_c%0d", c), if_ack, c == 7);
            checkOutput($sformatf("simul_mem_en_c%0d", c), mem_en, c == 1 || c == 5);
            if (c == 3) d_req = 1'b0;
            if (c == 7) if_req = 1'b0;
        end

        $display("[TB] starvation");
        @(negedge clk1);
        applyStimulus(1, 32'h0000_0004, 1, 0, 32'h0000_0014, 0);
        seq = '0;
        got = 0;
        for (int i = 0; i < 200 && got < 8; i++) begin
            @(negedge clk1);
            if (if_ack || d_ack) begin
                seq[got] = if_ack;
                got++;
            end
        end
        checkOutput("starve_grants", got, 8);
        checkOutput("starve_order", seq, 8'b1000_1000);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset mid-access");
        @(negedge clk1);
        applyStimulus(1, 32'h0000_0020, 0, 0, 0, 0);
        @(negedge clk1);
        @(negedge clk1);
        checkOutput("rst_wait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk1);
        checkOutput("rst_if_ack", if_ack, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        waitAck(1, 10, took);
        checkOutput("rerequest_lat", took, 3);
        checkOutput("rerequest_rdata", if_rdata, seed_word(8));
        if_req = 1'b0;

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk1);
            if (!if_req || if_ack) begin
                if_req = ($urandom_range(0, 1) == 1);
                if (if_req) if_addr = rand_addr();
            end
            if (!d_req || d_ack) begin
                d_req = ($urandom_range(0, 1) == 1);
                if (d_req) begin
                    d_we    = ($urandom_range(0, 2) == 0);
                    d_addr  = rand_addr();
                    d_wdata = $urandom();
                end
            end
        end
        for (int i = 0; i < 40 && (if_req || d_req); i++) begin
            @(negedge clk1);
            if (if_ack) if_req = 1'b0;
            if (d_ack) d_req = 1'b0;
        end
        checkOutput("drain_idle", {30'd0, if_req, d_req}, 0);
        repeat (6) @(negedge clk1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
